image_blit_engine: RTL and testbench
====================================

IMAGE_BLIT_ENGINE -- requirements
Module: image_blit_engine

Interface
REQ-001 The block SHALL have parameter COLOUR_W, default 3, meaning pixel colour width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning frame-buffer and image-memory address width in bits.
REQ-003 The block SHALL have parameter NUM_IMAGES, default 4, meaning the number of image memories attached (1..7).
REQ-004 The block SHALL have parameter OP_W, default 3, meaning opcode width in bits.
REQ-005 The block SHALL have parameter SCREEN_PIXELS, default 19200, meaning pixels per full-screen copy (at most 2^ADDR_W).
REQ-006 The block SHALL have port clk_in, input, 1 bit, meaning the single system clock; all logic SHALL be clocked on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit, meaning a request to begin a screen operation.
REQ-009 The block SHALL have port opcode, input, OP_W bits, meaning the operation selector sampled with start.
REQ-010 The block SHALL have port fill_colour, input, COLOUR_W bits, meaning the clear colour sampled with start.
REQ-011 The block SHALL have port abort, input, 1 bit, meaning terminate the current operation.
REQ-012 The block SHALL have port img_data, input, NUM_IMAGES*COLOUR_W bits, meaning read data of image k on bits [k*COLOUR_W +: COLOUR_W], valid one cycle after its address.
REQ-013 The block SHALL have port img_addr, output, ADDR_W bits, meaning the read address shared by all image memories.
REQ-014 The block SHALL have port img_rd_en, output, 1 bit, meaning img_addr is valid this cycle.
REQ-015 The block SHALL have port fb_wren, output, 1 bit, meaning write fb_data to fb_addr in the frame buffer this cycle.
REQ-016 The block SHALL have port fb_addr, output, ADDR_W bits, meaning the frame-buffer write address.
REQ-017 The block SHALL have port fb_data, output, COLOUR_W bits, meaning the frame-buffer write data.
REQ-018 The block SHALL have port busy, output, 1 bit, meaning an operation is in progress.
REQ-019 The block SHALL have port done, output, 1 bit, meaning a one-cycle pulse on completion or abort.
REQ-020 The block SHALL have port err, output, 1 bit, meaning the last opcode was invalid; held until the next accepted start.

Function
REQ-021 Opcode 0 SHALL select CLEAR: write fill_colour to every address 0..SCREEN_PIXELS-1, with img_rd_en held at 0.
REQ-022 Opcode k, for 1<=k<=NUM_IMAGES, SHALL select COPY from image k-1: read address a, then write img_data slice k-1 to fb_addr a.
REQ-023 Opcode > NUM_IMAGES SHALL assert err, issue no writes, and pulse done one cycle after start.
REQ-024 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN after address SCREEN_PIXELS-1 is issued.
- DRAIN -> DONE after the final write.
- DONE -> IDLE unconditionally.
REQ-025 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored.
REQ-026 opcode and fill_colour SHALL be registered at acceptance; later changes SHALL have no effect on the running operation.
REQ-027 The read counter SHALL begin at 0 in the cycle after acceptance and increment by 1 per cycle, with no stalls.
REQ-028 COPY latency:
- fb_wren, fb_addr and fb_data for address a SHALL appear exactly one cycle after img_addr=a.
- fb_addr SHALL be a one-stage delay of img_addr.
REQ-029 CLEAR SHALL use the same timing as COPY, so both modes take SCREEN_PIXELS+3 cycles from acceptance to the done pulse.
REQ-030 Each address SHALL be written exactly once per operation, in ascending order; no counter wrap-around beyond SCREEN_PIXELS-1 is permitted.
REQ-031 busy SHALL be 1 from the cycle after acceptance through the done cycle inclusive, and 0 otherwise.
REQ-032 abort in RUN or DRAIN SHALL:
- suppress img_rd_en immediately;
- allow any write whose read was already issued to complete;
- then go to DONE and pulse done.
REQ-033 When abort and start occur together in IDLE, start SHALL win and abort SHALL be ignored.
REQ-034 fb_wren SHALL never assert in IDLE or DONE.

Reset
REQ-035 On reset=1 at a clock edge:
- the FSM SHALL go to IDLE;
- busy, done, err, fb_wren and img_rd_en SHALL be 0;
- img_addr, fb_addr and fb_data SHALL be 0.
REQ-036 Reset mid-operation SHALL abandon the operation with no further writes and no done pulse; reset SHALL take priority over start and abort.

Verification
REQ-037 Scenario CLEAR, with SCREEN_PIXELS=16: opcode=0, fill_colour=3'b101, start -> 16 writes to addresses 0..15 with data 5, and done on cycle 19 after acceptance.
REQ-038 Scenario COPY: opcode=2, with image 1 returning (addr mod 8) one cycle late -> fb_data equals fb_addr mod 8 on every write, and img_addr leads fb_addr by exactly 1 cycle.
REQ-039 Scenario invalid opcode: opcode=5 with NUM_IMAGES=4 -> err=1, zero writes, done one cycle after start; err clears on the next valid start.
REQ-040 Scenario abort: abort asserted while img_addr=6 -> last write at fb_addr 5 or 6, matching the reads already issued, then done, then busy=0.
REQ-041 Scenario reset mid-copy: reset at img_addr=9 -> all outputs 0 next cycle, and no done pulse.
REQ-042 Scenario start while busy: a second start with opcode=1 mid-clear -> ignored, and the clear completes unchanged.

Source files
------------

// File: rtl/image_blit_engine.sv
// Screen blit engine: fills the frame buffer with a constant colour or copies one
// of several image memories into it, one pixel per clock, through a one-stage read pipeline.
module image_blit_engine #(
    parameter int COLOUR_W      = 3,
    parameter int ADDR_W        = 15,
    parameter int NUM_IMAGES    = 4,
    parameter int OP_W          = 3,
    parameter int SCREEN_PIXELS = 19200
) (
    input  logic                           clk_in,
    input  logic                           reset,
    input  logic                           start,
    input  logic [OP_W-1:0]                opcode,
    input  logic [COLOUR_W-1:0]            fill_colour,
    input  logic                           abort,
    input  logic [NUM_IMAGES*COLOUR_W-1:0] img_data,
    output logic [ADDR_W-1:0]              img_addr,
    output logic                           img_rd_en,
    output logic                           fb_wren,
    output logic [ADDR_W-1:0]              fb_addr,
    output logic [COLOUR_W-1:0]            fb_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_PIXELS - 1);
    localparam logic [OP_W-1:0]   MAX_OP    = OP_W'(NUM_IMAGES);

    state_t                state_q;
    logic [ADDR_W-1:0]     rdAddr_q;
    logic [ADDR_W-1:0]     wrAddr_q;
    logic                  rdEn_q;
    logic                  wrEn_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [OP_W-1:0]       op_q;
    logic [COLOUR_W-1:0]   fill_q;
    logic                  abortRun;
    logic [COLOUR_W-1:0]   imgPixel;

    // An abort withdraws the read presented this cycle so it never turns into a write.
    assign abortRun  = abort && (state_q == RUN);
    assign img_rd_en = rdEn_q && !abortRun;
    assign img_addr  = rdAddr_q;
    assign fb_wren   = wrEn_q;
    assign fb_addr   = wrAddr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // Image read data arrives one cycle after its address, which is exactly when the
    // matching write is on the bus, so the selected slice feeds fb_data directly.
    always_comb begin
        imgPixel = '0;
        for (int k = 0; k < NUM_IMAGES; k++) begin
            if (op_q == OP_W'(k + 1)) begin
                imgPixel = img_data[k*COLOUR_W +: COLOUR_W];
            end
        end
    end

    assign fb_data = !wrEn_q ? '0 : ((op_q == '0) ? fill_q : imgPixel);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            rdAddr_q <= '0;
            wrAddr_q <= '0;
            rdEn_q   <= 1'b0;
            wrEn_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= '0;
            fill_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            wrEn_q   <= img_rd_en;
            wrAddr_q <= rdAddr_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= opcode;
                        fill_q   <= fill_colour;
                        busy_q   <= 1'b1;
                        rdAddr_q <= '0;
                        if (opcode > MAX_OP) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            rdEn_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort || rdAddr_q == LAST_ADDR) begin
                        rdEn_q  <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rdAddr_q <= rdAddr_q + 1'b1;
                    end
                end
                // Leave only once the write pipeline has emptied.
                DRAIN: begin
                    if (!wrEn_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_blit_engine.sv
// Directed bench for image_blit_engine: expected frame-buffer writes are queued when an
// operation is launched and popped as the engine writes them.
module tb_image_blit_engine;

    localparam int CW   = 3;
    localparam int AW   = 15;
    localparam int NI   = 4;
    localparam int OW   = 3;
    localparam int NPIX = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wrT;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [OW-1:0]     opcode = '0;
    logic [CW-1:0]     fillColour = '0;
    logic              abort = 1'b0;
    logic [NI*CW-1:0]  imgData = '0;
    logic [AW-1:0]     imgAddr;
    logic              imgRdEn;
    logic              fbWren;
    logic [AW-1:0]     fbAddr;
    logic [CW-1:0]     fbData;
    logic              busy;
    logic              done;
    logic              err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int doneSeen = 0;
    int doneCyc = -1;
    int writesSeen = 0;
    int busyCnt = 0;
    logic [AW-1:0] prevAddr = '0;
    logic          prevRd = 1'b0;
    wrT expQ[$];

    image_blit_engine #(
        .COLOUR_W(CW), .ADDR_W(AW), .NUM_IMAGES(NI), .OP_W(OW), .SCREEN_PIXELS(NPIX)
    ) dut (
        .clk_in(clk), .reset(reset), .start(start), .opcode(opcode),
        .fill_colour(fillColour), .abort(abort), .img_data(imgData),
        .img_addr(imgAddr), .img_rd_en(imgRdEn), .fb_wren(fbWren), .fb_addr(fbAddr),
        .fb_data(fbData), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Contents of image k at address a; image 1 returns the address modulo 8.
    function automatic logic [CW-1:0] imgFn(int k, logic [AW-1:0] a);
        case (k)
            0:       return a[2:0] ^ 3'd3;
            1:       return a[2:0];
            2:       return 3'(a[2:0] * 3'd3);
            default: return ~a[2:0];
        endcase
    endfunction

    // Synchronous-read image memories: data for an address appears one clock later.
    always @(posedge clk) begin
        if (imgRdEn) begin
            for (int k = 0; k < NI; k++) begin
                imgData[k*CW +: CW] <= imgFn(k, imgAddr);
            end
        end
    end

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(logic st, logic [OW-1:0] op, logic [CW-1:0] fill);
        start      = st;
        opcode     = op;
        fillColour = fill;
    endtask

    task automatic clearStats();
        cyc        = 0;
        doneSeen   = 0;
        doneCyc    = -1;
        writesSeen = 0;
        busyCnt    = 0;
    endtask

    // One clock: sample on the falling edge and score any write against the queue.
    task automatic tick();
        wrT e;
        @(negedge clk);
        cyc++;
        if (busy) busyCnt++;
        if (fbWren) begin
            writesSeen++;
            checkOutput("queue_has_entry", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("wr_addr", fbAddr, e.addr);
                checkOutput("wr_data", fbData, e.data);
            end
            checkOutput("addr_lead", {prevRd, prevAddr}, {1'b1, fbAddr});
        end
        if (imgRdEn) checkOutput("rd_addr_range", imgAddr < NPIX, 1);
        if (done) begin
            doneSeen++;
            doneCyc = cyc;
            checkOutput("no_wr_in_done", fbWren, 0);
        end
        prevAddr = imgAddr;
        prevRd   = imgRdEn;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_outputs",
                    {busy, done, err, fbWren, imgRdEn, imgAddr, fbAddr, fbData}, '0);

        // CLEAR with colour 5, inputs changed after acceptance, second start mid-run
        expQ.delete();
        for (int a = 0; a < NPIX; a++) expQ.push_back({AW'(a), 3'd5});
        applyStimulus(1'b1, 3'd0, 3'b101);
        clearStats();
        tick();
        applyStimulus(1'b0, 3'd1, 3'd2);
        checkOutput("clear_first_cycle", {busy, imgRdEn, imgAddr}, {1'b1, 1'b1, 15'd0});
        for (int i = 0; i < 25; i++) begin
            if (i == 5) applyStimulus(1'b1, 3'd1, 3'd2);
            if (i == 6) applyStimulus(1'b0, 3'd1, 3'd2);
            tick();
        end
        checkOutput("clear_done_cycle", doneCyc, 19);
        checkOutput("clear_done_count", doneSeen, 1);
        checkOutput("clear_writes", writesSeen, NPIX);
        checkOutput("clear_queue_empty", expQ.size(), 0);
        checkOutput("clear_busy_cycles", busyCnt, 19);
        checkOutput("clear_idle", {busy, err}, 2'b00);

        // COPY from image 1 (addr mod 8)
        for (int a = 0; a < NPIX; a++) expQ.push_back({AW'(a), 3'(a % 8)});
        applyStimulus(1'b1, 3'd2, 3'd0);
        clearStats();
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 22; i++) tick();
        checkOutput("copy_done_cycle", doneCyc, 19);
        checkOutput("copy_writes", writesSeen, NPIX);
        checkOutput("copy_queue_empty", expQ.size(), 0);
        checkOutput("copy_idle", {busy, err}, 2'b00);

        // Invalid opcode: err, no writes, done one cycle after start
        applyStimulus(1'b1, 3'd5, 3'd1);
        clearStats();
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkOutput("inv_first_cycle", {done, err, busy, imgRdEn}, 4'b1110);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("inv_writes", writesSeen, 0);
        checkOutput("inv_done_count", doneSeen, 1);
        checkOutput("inv_err_held", {err, busy}, 2'b10);

        // Valid CLEAR after the invalid one clears err
        for (int a = 0; a < NPIX; a++) expQ.push_back({AW'(a), 3'd2});
        applyStimulus(1'b1, 3'd0, 3'd2);
        clearStats();
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkOutput("err_cleared", err, 0);
        for (int i = 0; i < 22; i++) tick();
        checkOutput("clear2_writes", writesSeen, NPIX);
        checkOutput("clear2_done_cycle", doneCyc, 19);

        // Abort COPY from image 3 while img_addr is 6: reads 0..5 complete
        for (int a = 0; a < 6; a++) expQ.push_back({AW'(a), ~3'(a)});
        applyStimulus(1'b1, 3'd4, 3'd0);
        clearStats();
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 20 && imgAddr != 15'd6; i++) tick();
        checkOutput("abort_reached_addr6", imgAddr, 6);
        abort = 1'b1;
        #1;
        checkOutput("abort_rd_suppressed", imgRdEn, 0);
        tick();
        abort = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checkOutput("abort_done_cycle", doneCyc, 9);
        checkOutput("abort_done_count", doneSeen, 1);
        checkOutput("abort_writes", writesSeen, 6);
        checkOutput("abort_queue_empty", expQ.size(), 0);
        checkOutput("abort_idle", busy, 0);

        // Reset during COPY from image 0 at img_addr 9
        for (int a = 0; a < 9; a++) expQ.push_back({AW'(a), 3'(a) ^ 3'd3});
        applyStimulus(1'b1, 3'd1, 3'd0);
        clearStats();
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 20 && imgAddr != 15'd9; i++) tick();
        checkOutput("rst_reached_addr9", imgAddr, 9);
        reset = 1'b1;
        tick();
        checkOutput("rst_outputs_zero",
                    {busy, done, err, fbWren, imgRdEn, imgAddr, fbAddr, fbData}, '0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("rst_no_done", doneSeen, 0);
        checkOutput("rst_writes", writesSeen, 9);
        checkOutput("rst_queue_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
